mod2_interp: RTL

- Linear-interpolating upsampler that feeds the 2nd-order sigma-delta DAC modulator.
- Accepts signed samples at the low system rate over a valid/ready handshake.
- Emits one interpolated sample per enabled clock (OSR = 2^LOG2_OSR steps per input sample), plus a run-enable level for the modulator.
- Sits between the sample source (register file / waveform generator) and the modulator's i_data/i_en.

---
 rtl/mod2_interp_pkg.sv | 22 ++
 rtl/mod2_interp_buf.sv | 44 ++++
 rtl/mod2_interp.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mod2_interp_pkg.sv
// Shared state encodings and width helpers for the mod2_interp upsampler.
`ifndef MOD2_INTERP_PKG_SV
`define MOD2_INTERP_PKG_SV
package mod2_interp_pkg;

  typedef enum logic [1:0] {
    S_FILL0 = 2'd0,
    S_FILL1 = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  // The accumulator holds x*OSR plus the (WIDTH+1)-bit slope sum without overflow.
  function automatic int acc_width(input int width, input int log2_osr);
    return width + 1 + log2_osr;
  endfunction

  function automatic int osr(input int log2_osr);
    return 1 << log2_osr;
  endfunction

endpackage
`endif

// File: rtl/mod2_interp_buf.sv
// One-entry sample holding register between the source and the interpolator.
// Latency: sample visible on pop_dat the cycle after push.
// Backpressure: push_rdy is registered and low while the entry is occupied.
module mod2_interp_buf
  import mod2_interp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic             push_rdy,
  output logic             full,
  output logic [WIDTH-1:0] pop_dat
);

  logic full_nxt;

  always_comb begin
    full_nxt = full;
    if (push_vld) begin
      full_nxt = 1'b1;
    end else if (pop_vld) begin
      full_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      push_rdy <= 1'b1;
      pop_dat  <= '0;
    end else begin
      full     <= full_nxt;
      push_rdy <= ~full_nxt;
      if (push_vld) begin
        pop_dat <= push_dat;
      end
    end
  end

endmodule

// File: rtl/mod2_interp.sv
// Linear-interpolating upsampler feeding the 2nd-order sigma-delta modulator.
// Latency: o_data=x0 one cycle after the second accepted sample; one step per enabled clock.
// Backpressure: o_ready low while the one-entry buffer holds a sample. MOD2_INTERP_HALF_SCALE_EN halves output.
module mod2_interp
  import mod2_interp_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOG2_OSR = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic signed [WIDTH-1:0] o_data,
  output logic                    o_active,
  output logic                    o_underrun,
  output logic                    o_underrun_sticky
);

  localparam int AW = acc_width(WIDTH, LOG2_OSR);
  localparam int OSR = osr(LOG2_OSR);
  localparam logic [LOG2_OSR-1:0] PHASE_LAST = LOG2_OSR'(OSR - 1);
`ifdef MOD2_INTERP_HALF_SCALE_EN
  localparam int OUT_SHIFT = LOG2_OSR + 1;
`else
  localparam int OUT_SHIFT = LOG2_OSR;
`endif

  state_t                    state;
  logic signed [WIDTH-1:0]   x0, x1;
  logic signed [WIDTH:0]     delta;
  logic signed [AW-1:0]      acc, acc_nxt;
  logic [LOG2_OSR-1:0]       phase;
  logic signed [WIDTH-1:0]   data_q;
  logic                      underrun_q, sticky_q;

  logic                      accept, run, boundary;
  logic                      buf_rdy, buf_full, buf_push_vld, buf_pop_vld;
  logic [WIDTH-1:0]          buf_dat;

  function automatic logic signed [AW-1:0] scale_up(input logic signed [WIDTH-1:0] x);
    return {x[WIDTH-1], x, {LOG2_OSR{1'b0}}};
  endfunction

  function automatic logic signed [WIDTH:0] diff(input logic signed [WIDTH-1:0] a,
                                                 input logic signed [WIDTH-1:0] b);
    return {a[WIDTH-1], a} - {b[WIDTH-1], b};
  endfunction

  assign run          = (state == S_RUN);
  assign accept       = i_valid && buf_rdy;
  assign boundary     = run && i_en && (phase == PHASE_LAST);
  assign buf_push_vld = accept && run;
  assign buf_pop_vld  = boundary && buf_full;

  mod2_interp_buf #(.WIDTH(WIDTH)) u_sbuf (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .push_vld (buf_push_vld),
    .push_dat (i_data),
    .pop_vld  (buf_pop_vld),
    .push_rdy (buf_rdy),
    .full     (buf_full),
    .pop_dat  (buf_dat)
  );

  // Each frame restarts exactly at x*OSR so rounding never drifts across frames.
  always_comb begin
    acc_nxt = acc;
    case (state)
      S_FILL1: if (accept) acc_nxt = scale_up(x0);
      S_RUN: begin
        if (i_en) begin
          if (phase == PHASE_LAST) acc_nxt = scale_up(x1);
          else acc_nxt = acc + {{LOG2_OSR{delta[WIDTH]}}, delta};
        end
      end
      default: acc_nxt = acc;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_FILL0;
      x0         <= '0;
      x1         <= '0;
      delta      <= '0;
      acc        <= '0;
      phase      <= '0;
      data_q     <= '0;
      underrun_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      acc        <= acc_nxt;
      data_q     <= acc_nxt[OUT_SHIFT +: WIDTH];
      case (state)
        S_FILL0: begin
          if (accept) begin
            x0    <= i_data;
            state <= S_FILL1;
          end
        end
        S_FILL1: begin
          if (accept) begin
            x1    <= i_data;
            delta <= diff(i_data, x0);
            phase <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_en) begin
            if (phase == PHASE_LAST) begin
              phase <= '0;
              x0    <= x1;
              if (buf_full) begin
                x1    <= buf_dat;
                delta <= diff(buf_dat, x1);
              end else begin
                // Starved frame: hold the last sample flat.
                delta      <= '0;
                underrun_q <= 1'b1;
                sticky_q   <= 1'b1;
              end
            end else begin
              phase <= phase + LOG2_OSR'(1);
            end
          end
        end
        default: state <= S_FILL0;
      endcase
    end
  end

  assign o_ready           = buf_rdy;
  assign o_data            = data_q;
  assign o_active          = run && i_en;
  assign o_underrun        = underrun_q;
  assign o_underrun_sticky = sticky_q;

endmodule
